// File: rtl/uart_tx.sv
// Serial UART transmitter: start bit, 8 data bits LSB first, odd parity, stop bit.
// The line idles high and every bit is held for CLK_FREQUENCY/BAUD_RATE clocks.
module uart_tx #(
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned BAUD_RATE     = 19_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] din,
    output logic       tx_out,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned BAUD_CYCLES = CLK_FREQUENCY / BAUD_RATE;
    localparam int unsigned CNT_W       = (BAUD_CYCLES > 1) ? $clog2(BAUD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_LOW
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             par_q;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;
    logic             baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            baud_q <= baud_end ? '0 : baud_q + 1'b1;
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (send) begin
                        shift_q <= din;
                        par_q   <= ~^din;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        tx_q    <= shift_q[0];
                        bit_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        // shift_q[1] is the bit that becomes LSB after this shift
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            tx_q    <= par_q;
                            state_q <= PARITY;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (baud_end) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    // a held send must be released before another frame is accepted
                    baud_q <= '0;
                    if (!send) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_out  = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: drives bytes and checks the serial line cycle by cycle
// against a frame built from the byte with plain arithmetic, plus a mid-bit decoder.
module tb_uart_tx;

    localparam int unsigned CLK_FREQUENCY = 1000;
    localparam int unsigned BAUD_RATE     = 100;
    localparam int unsigned BAUD          = CLK_FREQUENCY / BAUD_RATE;

    logic       clk;
    logic       rst;
    logic       send;
    logic [7:0] din;
    logic       tx_out;
    logic       busy;
    logic       tx_done;

    int n_total = 0;
    int n_pass  = 0;

    uart_tx #(
        .CLK_FREQUENCY(CLK_FREQUENCY),
        .BAUD_RATE    (BAUD_RATE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .send   (send),
        .din    (din),
        .tx_out (tx_out),
        .busy   (busy),
        .tx_done(tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"}, {31'd0, tx_out}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, tx_done}, 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_idle("idle");
        end
    endtask

    // Raise send at the current negedge for one cycle; returns at the first negedge
    // after the accepting edge. din is scrambled afterwards to prove it was latched.
    task automatic pulse_send(input logic [7:0] d);
        din  = d;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        din  = ~d;
    endtask

    // Called at the first negedge after the accepting edge; walks all 11 bits.
    task automatic check_frame(input logic [7:0] d);
        logic [10:0] expect_bits;
        logic [10:0] mid;
        int          ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        expect_bits[0]   = 1'b0;
        expect_bits[8:1] = d;
        expect_bits[9]   = (ones % 2 == 0);
        expect_bits[10]  = 1'b1;
        mid = '0;
        for (int k = 0; k < 11; k++) begin
            for (int c = 0; c < int'(BAUD); c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                check("frame_tx", {31'd0, tx_out}, {31'd0, expect_bits[k]});
                check("frame_busy", {31'd0, busy}, 32'd1);
                check("frame_done", {31'd0, tx_done}, 32'd0);
                if (c == int'(BAUD) / 2) mid[k] = tx_out;
            end
        end
        @(negedge clk);
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_done", {31'd0, tx_done}, 32'd1);
        check("end_tx", {31'd0, tx_out}, 32'd1);
        ones = 0;
        for (int i = 1; i <= 9; i++) ones += int'(mid[i]);
        check("dec_start", {31'd0, mid[0]}, 32'd0);
        check("dec_data", {24'd0, mid[8:1]}, {24'd0, d});
        check("dec_oddpar", ones % 2, 1);
        check("dec_stop", {31'd0, mid[10]}, 32'd1);
    endtask

    initial begin
        logic [7:0] fixed_bytes [4];
        logic [7:0] r;
        fixed_bytes[0] = 8'h41;
        fixed_bytes[1] = 8'h00;
        fixed_bytes[2] = 8'hFF;
        fixed_bytes[3] = 8'h07;

        rst  = 1'b1;
        send = 1'b0;
        din  = 8'h00;
        #1;
        check_idle("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_cycles(3);

        // Async reset while idle, between clock edges
        #2 rst = 1'b1;
        #1 check_idle("rst_async_idle");
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        // Directed bytes including the parity corner cases
        for (int i = 0; i < 4; i++) begin
            pulse_send(fixed_bytes[i]);
            check_frame(fixed_bytes[i]);
            idle_cycles(3);
        end

        // Held send: one frame only while send stays high
        din  = 8'h55;
        send = 1'b1;
        @(negedge clk);
        fork
            begin
                check_frame(8'h55);
                idle_cycles(200);
            end
            begin
                repeat (299) @(negedge clk);
                send = 1'b0;
            end
        join
        pulse_send(8'h5A);
        check_frame(8'h5A);
        idle_cycles(2);

        // din change and send pulse while busy must not disturb or follow the frame
        pulse_send(8'h3C);
        fork
            check_frame(8'h3C);
            begin
                repeat (30) @(negedge clk);
                din  = 8'hAA;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        join
        idle_cycles(30);

        // Random bytes with random gaps, down to the minimum back-to-back spacing
        for (int i = 0; i < 6; i++) begin
            r = 8'($urandom);
            pulse_send(r);
            check_frame(r);
            idle_cycles(int'($urandom_range(1, 4)));
        end

        // Reset during data bit 3 aborts at once; next frame is clean
        pulse_send(8'hC6);
        repeat (4 * BAUD + 3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle("rst_mid_frame");
        @(negedge clk);
        check_idle("rst_held");
        rst = 1'b0;
        idle_cycles(3);
        pulse_send(8'h31);
        check_frame(8'h31);
        idle_cycles(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
